cache_arbiter: RTL and testbench
================================

# cache_arbiter

Arbitrates the split L1 instruction and data caches onto the single shared physical-memory (L2/burst) port. It serialises line fills and write-backs, routes `pmem_resp` and read data back to exactly one cache, and is the source of the `instr_mem_resp` and `data_mem_resp` stalls seen by the pipeline's stall control. It sits between the two caches and the memory-side cacheline adaptor.

## Interface
- `ADDR_WIDTH`, 32, byte address width; line-aligned, low 5 bits zero.
- `LINE_WIDTH`, 256, cacheline width in bits.
- `clk  in  1  core clock`
- `rst  in  1  asynchronous, active-low reset`
- `i_pmem_read  in  1  I-cache line-read request; held until its resp`
- `i_pmem_address  in  ADDR_WIDTH  I-cache line address`
- `i_pmem_rdata  out  LINE_WIDTH  line data to I-cache`
- `i_pmem_resp  out  1  one-cycle completion pulse to I-cache`
- `d_pmem_read  in  1  D-cache line-read request; held until its resp`
- `d_pmem_write  in  1  D-cache write-back request; never asserted together with d_pmem_read`
- `d_pmem_address  in  ADDR_WIDTH  D-cache line address`
- `d_pmem_wdata  in  LINE_WIDTH  write-back line`
- `d_pmem_rdata  out  LINE_WIDTH  line data to D-cache`
- `d_pmem_resp  out  1  one-cycle completion pulse to D-cache`
- `pmem_read  out  1  memory read request; held until pmem_resp`
- `pmem_write  out  1  memory write request; held until pmem_resp`
- `pmem_address  out  ADDR_WIDTH  memory address`
- `pmem_wdata  out  LINE_WIDTH  memory write data`
- `pmem_rdata  in  LINE_WIDTH  memory read data, valid with pmem_resp`
- `pmem_resp  in  1  memory completion pulse`

## Operation
- States:
  - IDLE: no grant.
  - SERVE_I: I-cache owns the port.
  - SERVE_D: D-cache owns the port.
  - RECOVER: one dead cycle after each completion.
- IDLE:
  - If the pick logic selects a requester, latch the grant and the request (address, wdata, read/write) into registers.
  - Go to SERVE_I or SERVE_D.
- SERVE_x:
  - Drive `pmem_*` from the latched registers, never from live client inputs.
  - On `pmem_resp`: pulse `x_pmem_resp` in the same cycle and pass `pmem_rdata` to `x_pmem_rdata`; go to RECOVER.
- RECOVER:
  - No memory request is driven and no grant is made.
  - Gives the completed client one cycle to drop its request, so a stale request is never re-granted.
  - Then go to IDLE.
- Default pick: D-cache has priority. A pending D request wins over a simultaneous I request.
- Non-granted client: `resp` = 0. Its `rdata` output carries `pmem_rdata` and is don't-care.
- Request dropped by the client mid-service: illegal. The arbiter completes the latched transaction anyway.
- Reset (asynchronous, any state, including mid-transaction):
  - State returns to IDLE; grant and latched request are cleared.
  - All `pmem_*` and `*_resp` outputs go to 0 immediately.
  - The in-flight memory transaction is abandoned; memory is reset by the same `rst`.

## Timing
- Reset values: every output is 0.
- Grant latency: a request seen in IDLE at edge N produces `pmem_read`/`pmem_write` from cycle N+1.
- Response path: `pmem_resp` → `x_pmem_resp` is combinational, zero cycles.
- Minimum gap between two memory transactions: 2 cycles (RECOVER + IDLE).
- Back-to-back throughput: one transaction per (memory latency + 2) cycles.
- `pmem_read`/`pmem_write` are constant for the whole of SERVE_x.

## Configuration
- `CACHE_ARBITER_RR_EN`
  - Defined: round-robin pick. A 1-bit `last_grant` register, reset to I, records the last owner. When both caches request in IDLE, the client that was not `last_grant` wins. A single requester always wins.
  - Undefined: fixed D-over-I priority; no `last_grant` register exists.

## Structure
- Shared package `rv32i_types` gains:
  - `arb_state_t`: enum {IDLE, SERVE_I, SERVE_D, RECOVER}
  - `arb_grant_t`: enum {GRANT_I, GRANT_D}
- Sub-module `arbiter_pick` (combinational):
  - Inputs: `i_req`, `d_req`, `last_grant`.
  - Output: `arb_grant_t` plus a `valid` bit.
  - Isolates the policy that `CACHE_ARBITER_RR_EN` switches.

## Test plan
- I-only read: `i_pmem_read`=1, addr 0x0000_0060; memory responds after 5 cycles with 256'hA5…
  - `pmem_read` rises 1 cycle after the request, address 0x60.
  - `i_pmem_resp` pulses once with the data; `d_pmem_resp` stays 0.
- Simultaneous I read 0x100 and D write 0x200, fixed priority:
  - D write is issued first with `d_pmem_wdata`.
  - After RECOVER + IDLE, the I read is issued.
  - Gap between `pmem_write` falling and `pmem_read` rising is exactly 2 cycles.
- `CACHE_ARBITER_RR_EN`, both caches request continuously for 4 transactions:
  - Grant order is D, I, D, I.
- Client holds its request one cycle past resp:
  - No second memory transaction is issued during RECOVER.
- Async reset mid-SERVE_D, `rst` low between clock edges:
  - All outputs drop to 0 immediately.
  - After release, state is IDLE and a new I request is granted normally.
- Address/data stability: `d_pmem_address` toggled during SERVE_D:
  - `pmem_address` holds the latched value until `pmem_resp`.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache to physical-memory arbiter.
package cache_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RECOVER
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/cache_arbiter_pick.sv
// Grant policy for the cache arbiter: fixed D-over-I priority, or round-robin
// when CACHE_ARBITER_RR_EN is defined.
module cache_arbiter_pick
  import cache_arbiter_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_grant_t last_grant,
  output arb_grant_t grant,
  output logic       valid
);

  always_comb begin
    valid = i_req | d_req;
    grant = GRANT_D;
`ifdef CACHE_ARBITER_RR_EN
    if (i_req && d_req) begin
      grant = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (i_req) begin
      grant = GRANT_I;
    end
`else
    if (!d_req) begin
      grant = GRANT_I;
    end
`endif
  end

`ifndef CACHE_ARBITER_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Serialises I-cache fills and D-cache fills/write-backs onto one memory port.
// Define CACHE_ARBITER_RR_EN for round-robin instead of fixed D priority.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  arb_grant_t            last_grant, pick_grant;
  logic                  pick_valid;
  logic                  serving;

  cache_arbiter_pick u_pick (
    .i_req      (i_pmem_read),
    .d_req      (d_pmem_read | d_pmem_write),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

`ifdef CACHE_ARBITER_RR_EN
  arb_grant_t last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && pick_valid) begin
      last_grant_d = pick_grant;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GRANT_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = GRANT_I;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          if (pick_grant == GRANT_D) begin
            state_d = SERVE_D;
            addr_d  = d_pmem_address;
            wdata_d = d_pmem_wdata;
            write_d = d_pmem_write;
          end else begin
            state_d = SERVE_I;
            addr_d  = i_pmem_address;
            wdata_d = '0;
            write_d = 1'b0;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = RECOVER;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  // Memory side is driven only from the latched request, so client inputs may move mid-service.
  assign serving      = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign pmem_read    = serving & ~write_q;
  assign pmem_write   = serving & write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized client traffic.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
`ifdef CACHE_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_pmem_read = 1'b0;
  logic [AW-1:0] i_pmem_address = '0;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [AW-1:0] d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: owner 0=none 1=I 2=D; one dead cycle after each completion.
  int            m_owner = 0;
  int            m_dead  = 0;
  int            m_last  = 1;
  logic [AW-1:0] m_addr  = '0;
  logic [LW-1:0] m_wdata = '0;
  logic          m_isw   = 1'b0;

  always @(posedge clk or negedge rst) begin
    int who;
    if (!rst) begin
      m_owner = 0; m_dead = 0; m_last = 1;
      m_addr = '0; m_wdata = '0; m_isw = 1'b0;
    end else if (m_owner != 0) begin
      if (pmem_resp) begin
        m_owner = 0;
        m_dead  = 1;
      end
    end else if (m_dead > 0) begin
      m_dead--;
    end else begin
      who = 0;
      if ((d_pmem_read || d_pmem_write) && i_pmem_read) who = RR ? ((m_last == 2) ? 1 : 2) : 2;
      else if (d_pmem_read || d_pmem_write) who = 2;
      else if (i_pmem_read) who = 1;
      if (who == 2) begin
        m_addr = d_pmem_address; m_wdata = d_pmem_wdata; m_isw = d_pmem_write;
      end else if (who == 1) begin
        m_addr = i_pmem_address; m_isw = 1'b0;
      end
      if (who != 0) begin
        m_owner = who;
        m_last  = who;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_pmem_read", pmem_read, 0);
      chk("rst_pmem_write", pmem_write, 0);
      chk("rst_i_resp", i_pmem_resp, 0);
      chk("rst_d_resp", d_pmem_resp, 0);
    end else begin
      chk("pmem_read", pmem_read, (m_owner != 0) && !m_isw);
      chk("pmem_write", pmem_write, (m_owner != 0) && m_isw);
      if (m_owner != 0) chk("pmem_address", pmem_address, m_addr);
      if (m_owner != 0 && m_isw) chk("pmem_wdata", pmem_wdata, m_wdata);
      chk("i_resp", i_pmem_resp, (m_owner == 1) && pmem_resp);
      chk("d_resp", d_pmem_resp, (m_owner == 2) && pmem_resp);
      if (m_owner == 1 && pmem_resp) chk("i_rdata", i_pmem_rdata, pmem_rdata);
      if (m_owner == 2 && pmem_resp) chk("d_rdata", d_pmem_rdata, pmem_rdata);
    end
  end

  // Environment: memory with configurable latency, clients that hold until resp.
  bit            fixed_lat = 1'b1;
  int            lat = 5;
  logic [LW-1:0] fixed_data = '0;
  bit            mem_active = 1'b0;
  int            mem_cnt = 0;
  bit            auto_cl = 1'b0;
  bit            persist = 1'b0;
  int            i_extra = 0, d_extra = 0;
  int            i_left = -1, d_left = -1;
  int            cyc = 0, s_cyc = 0;
  logic          s_i_resp, s_d_resp, s_read, s_write;
  logic [AW-1:0] s_addr;
  logic [LW-1:0] s_wdata, s_i_rdata;

  function automatic logic [AW-1:0] rand_line();
    return $urandom() & 32'hFFFF_FFE0;
  endfunction

  function automatic logic [LW-1:0] rand_line_data();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    s_cyc = cyc;
    s_i_resp = i_pmem_resp; s_d_resp = d_pmem_resp;
    s_read = pmem_read; s_write = pmem_write;
    s_addr = pmem_address; s_wdata = pmem_wdata; s_i_rdata = i_pmem_rdata;
    if ((s_read || s_write) && !mem_active) begin
      mem_active = 1'b1;
      mem_cnt = (fixed_lat ? lat : int'($urandom_range(7, 2))) - 1;
    end
    @(posedge clk);
    #1;
    if (pmem_resp) begin
      pmem_resp = 1'b0; pmem_rdata = '0; mem_active = 1'b0;
    end else if (mem_active) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = fixed_lat ? fixed_data : rand_line_data();
      end
    end
    if (s_i_resp && !persist) i_left = i_extra;
    if (i_left == 0) i_pmem_read = 1'b0;
    if (i_left >= 0) i_left--;
    if (s_d_resp && !persist) d_left = d_extra;
    if (d_left == 0) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
    if (d_left >= 0) d_left--;
    if (auto_cl) begin
      if (!i_pmem_read && i_left < 0 && $urandom_range(3) == 0) begin
        i_pmem_read = 1'b1; i_pmem_address = rand_line(); i_extra = $urandom_range(1);
      end
      if (!d_pmem_read && !d_pmem_write && d_left < 0 && $urandom_range(3) == 0) begin
        d_pmem_write = $urandom_range(1); d_pmem_read = !d_pmem_write;
        d_pmem_address = rand_line(); d_pmem_wdata = rand_line_data(); d_extra = $urandom_range(1);
      end
      if (i_pmem_read && $urandom_range(2) == 0) i_pmem_address = rand_line();
      if ((d_pmem_read || d_pmem_write) && $urandom_range(2) == 0) begin
        d_pmem_address = rand_line(); d_pmem_wdata = rand_line_data();
      end
    end
    cyc++;
  endtask

  int            rise, rc, n_i, n_d, w_rise, w_fall, r_rise, n_busy, bad, order_n, bound;
  int            order [4];
  logic [AW-1:0] a_rise, w_addr, r_addr;
  logic [LW-1:0] got_data, w_data;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pmem_read", pmem_read, 0);
    chk("reset_pmem_write", pmem_write, 0);
    chk("reset_pmem_address", pmem_address, 0);
    chk("reset_pmem_wdata", pmem_wdata, 0);
    chk("reset_resps", {i_pmem_resp, d_pmem_resp}, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // I-only read of 0x60, latency 5
    fixed_lat = 1'b1; lat = 5; fixed_data = {32{8'hA5}};
    i_extra = 0; i_pmem_read = 1'b1; i_pmem_address = 32'h60; cyc = 0;
    rise = -1; rc = -1; n_i = 0; n_d = 0; got_data = '0; a_rise = '0;
    repeat (12) begin
      tick();
      if (s_read && rise < 0) begin rise = s_cyc; a_rise = s_addr; end
      if (s_i_resp) begin n_i++; rc = s_cyc; got_data = s_i_rdata; end
      if (s_d_resp) n_d++;
    end
    chk("t1_read_rise", rise, 1);
    chk("t1_addr", a_rise, 32'h60);
    chk("t1_resp_cycle", rc, 5);
    chk("t1_i_resp_count", n_i, 1);
    chk("t1_d_resp_count", n_d, 0);
    chk("t1_rdata", got_data, {32{8'hA5}});

    // Simultaneous I read 0x100 and D write 0x200
    w_data = {8{32'hDEAD_BEEF}};
    d_extra = 0; i_pmem_read = 1'b1; i_pmem_address = 32'h100;
    d_pmem_write = 1'b1; d_pmem_address = 32'h200; d_pmem_wdata = w_data; cyc = 0;
    w_rise = -1; w_fall = -1; r_rise = -1; w_addr = '0; r_addr = '0; got_data = '0;
    repeat (20) begin
      tick();
      if (s_write && w_rise < 0) begin w_rise = s_cyc; w_addr = s_addr; got_data = s_wdata; end
      if (!s_write && w_rise >= 0 && w_fall < 0) w_fall = s_cyc;
      if (s_read && r_rise < 0) begin r_rise = s_cyc; r_addr = s_addr; end
    end
    chk("t2_write_first", w_rise, 1);
    chk("t2_write_addr", w_addr, 32'h200);
    chk("t2_write_data", got_data, w_data);
    chk("t2_gap", r_rise - w_fall, 2);
    chk("t2_read_addr", r_addr, 32'h100);

    // Both clients request continuously for four transactions
    lat = 3; persist = 1'b1; order_n = 0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h20; d_pmem_read = 1'b1; d_pmem_address = 32'h40;
    bound = 0;
    while (order_n < 4 && bound < 60) begin
      tick();
      bound++;
      if (s_i_resp) begin order[order_n] = 1; order_n++; end
      else if (s_d_resp) begin order[order_n] = 2; order_n++; end
    end
    persist = 1'b0; i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    chk("t3_count", order_n, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("t3_grant%0d", k), order[k], (RR && (k % 2 == 1)) ? 1 : 2);
    repeat (4) tick();

    // Client holds its request one cycle past resp
    lat = 4; i_extra = 1; i_pmem_read = 1'b1; i_pmem_address = 32'h80;
    bound = 0; n_i = 0;
    while (n_i == 0 && bound < 20) begin
      tick(); bound++;
      if (s_i_resp) n_i++;
    end
    chk("t4_resp_seen", n_i, 1);
    n_busy = 0;
    repeat (6) begin
      tick();
      if (s_read || s_write) n_busy++;
    end
    chk("t4_no_regrant", n_busy, 0);
    i_extra = 0;

    // Asynchronous reset in the middle of a D read
    lat = 10; d_pmem_read = 1'b1; d_pmem_address = 32'h300;
    repeat (4) tick();
    chk("t5_pre_busy", pmem_read, 1);
    #3 rst = 1'b0;
    #1;
    chk("t5_pmem_read", pmem_read, 0);
    chk("t5_pmem_write", pmem_write, 0);
    chk("t5_pmem_address", pmem_address, 0);
    chk("t5_resps", {i_pmem_resp, d_pmem_resp}, 0);
    d_pmem_read = 1'b0; d_left = -1; mem_active = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    lat = 3; i_pmem_read = 1'b1; i_pmem_address = 32'h400; cyc = 0;
    rise = -1; a_rise = '0; n_i = 0; bound = 0;
    while (n_i == 0 && bound < 20) begin
      tick(); bound++;
      if (s_read && rise < 0) begin rise = s_cyc; a_rise = s_addr; end
      if (s_i_resp) n_i++;
    end
    chk("t5_i_rise", rise, 1);
    chk("t5_i_addr", a_rise, 32'h400);
    chk("t5_i_resp", n_i, 1);
    repeat (3) tick();

    // D address toggled while the read is in service
    lat = 6; d_pmem_read = 1'b1; d_pmem_address = 32'h500;
    n_busy = 0; bad = 0; n_d = 0; bound = 0;
    while (n_d == 0 && bound < 20) begin
      tick(); bound++;
      if (s_read) begin n_busy++; if (s_addr !== 32'h500) bad++; end
      if (s_d_resp) n_d++;
      d_pmem_address = rand_line();
    end
    chk("t6_addr_stable", bad, 0);
    chk("t6_busy_cycles", n_busy, 6);
    repeat (3) tick();

    // Randomized traffic against the model
    fixed_lat = 1'b0; auto_cl = 1'b1;
    repeat (400) tick();
    auto_cl = 1'b0;
    bound = 0;
    while ((i_pmem_read || d_pmem_read || d_pmem_write || s_read || s_write) && bound < 100) begin
      tick(); bound++;
    end
    chk("drain_done", bound < 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
